// File: rtl/ram_ctrl_pkg.sv
// Shared types for the single-port RAM controller: sequencer state and
// address-width helper.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  // A one-entry RAM still needs a one-bit address port.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid index at or after the pointer,
// and moves the pointer past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter  int NUM_REQ   = 2,
  localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   valid,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_any,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  logic [IDX_WIDTH-1:0] ptr_r;
  logic [IDX_WIDTH-1:0] cand_s;
  logic [IDX_WIDTH-1:0] idx_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic                 found_s;

  // Priority search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IDX_WIDTH'((int'(ptr_r) + k) % NUM_REQ);
      if (enable && !found_s && valid[cand_s]) begin
        grant_s[cand_s] = 1'b1;
        found_s         = 1'b1;
        idx_s           = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant implies valid, so every grant is an accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= IDX_WIDTH'((int'(idx_s) + 32'sd1) % NUM_REQ);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant     = grant_s;
  assign grant_any = found_s;
  assign grant_idx = idx_s;

endmodule

// File: rtl/ram_sp_rr_ctrl.sv
// Shares one single-port bit-masked RAM between NUM_REQ requesters with
// round-robin arbitration, plus a whole-array fill sequencer.
module ram_sp_rr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int NUM_REQ    = 2,
  localparam int ADDR_WIDTH = addr_bits(DEPTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wen,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bwen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  input  logic                          fill_start,
  input  logic [DATA_WIDTH-1:0]         fill_data,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          ram_cen,
  output logic                          ram_wen,
  output logic [DATA_WIDTH-1:0]         ram_bwen,
  output logic [DATA_WIDTH-1:0]         ram_din,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);

  localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ctrl_state_e           state_r, state_s;
  logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0] pattern_r, pattern_s;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic                  busy_r, done_r;
  logic                  arb_en_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  grant_any_s;
  logic [IDX_WIDTH-1:0]  grant_idx_s;

  assign arb_en_s = (state_r != FILL);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .enable    (arb_en_s),
    .valid     (req_valid),
    .grant     (grant_s),
    .grant_any (grant_any_s),
    .grant_idx (grant_idx_s)
  );

  // Fill sequencer next state, counter and pattern capture.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pattern_s = pattern_r;
    case (state_r)
      IDLE: begin
        if (fill_start) begin
          state_s   = FILL;
          cnt_s     = '0;
          pattern_s = fill_data;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        cnt_s = cnt_r + 1'b1;
        if (cnt_r == ADDR_WIDTH'(DEPTH - 1)) begin
          state_s = DONE;
        end else begin
          state_s = FILL;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, fill status flags and read-response strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      pattern_r   <= '0;
      rsp_valid_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      pattern_r   <= pattern_s;
      rsp_valid_r <= grant_s & ~req_wen;
      busy_r      <= (state_s == FILL);
      done_r      <= (state_s == DONE);
    end
  end

  // RAM port mux: fill owns the port while active, otherwise the granted requester.
  always_comb begin
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_bwen = '0;
    ram_din  = '0;
    ram_addr = '0;
    if (state_r == FILL) begin
      ram_cen  = 1'b1;
      ram_wen  = 1'b1;
      ram_bwen = '1;
      ram_din  = pattern_r;
      ram_addr = cnt_r;
    end else if (grant_any_s) begin
      ram_cen  = 1'b1;
      ram_wen  = req_wen[grant_idx_s];
      ram_bwen = req_bwen[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
      ram_din  = req_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
      ram_addr = req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin
      ram_cen = 1'b0;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = ram_dout;
  assign fill_busy = busy_r;
  assign fill_done = done_r;

endmodule

// File: tb/tb_ram_sp_rr_ctrl.sv
// Directed bench for ram_sp_rr_ctrl with a behavioural bit-masked RAM
// (registered read, output holds when not reading).
module tb_ram_sp_rr_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_wen, rsp_valid;
  logic [63:0] req_bwen, req_wdata;
  logic [7:0]  req_addr;
  logic [31:0] rsp_rdata, fill_data, ram_bwen, ram_din, ram_dout;
  logic        fill_start, fill_busy, fill_done, ram_cen, ram_wen;
  logic [3:0]  ram_addr;
  logic        mem_init;
  logic [31:0] mem [0:15];

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles, done_pulses;

  always #5 clock = ~clock;

  ram_sp_rr_ctrl #(.DATA_WIDTH(32), .DEPTH(16), .NUM_REQ(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_bwen(req_bwen), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .fill_start(fill_start), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_bwen(ram_bwen),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] preload_value(input int i);
    case (i)
      2:       return 32'h1234_5678;
      3:       return 32'hDEAD_BEEF;
      5:       return 32'h0000_0000;
      8:       return 32'h1111_1111;
      9:       return 32'h2222_2222;
      default: return 32'hC0DE_0000 + 32'(i);
    endcase
  endfunction

  // RAM model; contents are loaded once while mem_init is high.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= preload_value(i);
      ram_dout <= 32'h0;
    end else if (ram_cen) begin
      if (ram_wen) mem[ram_addr] <= (mem[ram_addr] & ~ram_bwen) | (ram_din & ram_bwen);
      else ram_dout <= mem[ram_addr];
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge that shows the response.
  task automatic do_read(input int r, input logic [3:0] addr, input logic [31:0] exp, input string tag);
    req_valid    = 2'b00;
    req_valid[r] = 1'b1;
    req_wen[r]   = 1'b0;
    req_addr[r*4 +: 4] = addr;
    #1 check_value({tag, "_ready"}, 32'(req_ready), 32'd1 << r);
    @(negedge clock);
    req_valid = 2'b00;
    check_value({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1 << r);
    check_value({tag, "_rdata"}, rsp_rdata, exp);
  endtask

  task automatic do_write(input int r, input logic [3:0] addr, input logic [31:0] data,
                          input logic [31:0] bwen, input string tag);
    req_valid    = 2'b00;
    req_valid[r] = 1'b1;
    req_wen[r]   = 1'b1;
    req_addr[r*4 +: 4]   = addr;
    req_wdata[r*32 +: 32] = data;
    req_bwen[r*32 +: 32]  = bwen;
    #1 check_value({tag, "_ready"}, 32'(req_ready), 32'd1 << r);
    @(negedge clock);
    req_valid  = 2'b00;
    req_wen[r] = 1'b0;
    check_value({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 2'b00; req_wen = 2'b00; req_bwen = 64'h0; req_wdata = 64'h0;
    req_addr = 8'h0; fill_start = 1'b0; fill_data = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0; mem_init = 1'b0;
    #1;
    check_value("rst_ready",     32'(req_ready), 32'd0);
    check_value("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("rst_busy",      32'(fill_busy), 32'd0);
    check_value("rst_done",      32'(fill_done), 32'd0);
    check_value("rst_ram_cen",   32'(ram_cen),   32'd0);
    check_value("rst_ram_wen",   32'(ram_wen),   32'd0);
    check_value("rst_ram_bwen",  ram_bwen,       32'd0);
    check_value("rst_ram_addr",  32'(ram_addr),  32'd0);
    check_value("rst_ram_din",   ram_din,        32'd0);
    @(negedge clock);

    do_read(0, 4'd3, 32'hDEAD_BEEF, "rd_addr3");

    do_write(1, 4'd5, 32'hFFFF_0000, 32'hFF00_FF00, "wr_masked");
    do_read(1, 4'd5, 32'hFF00_0000, "rd_masked");

    // Both requesters read continuously: grants alternate starting at 0.
    req_valid = 2'b11; req_wen = 2'b00; req_addr = {4'd9, 4'd8};
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        check_value("rr_rsp_valid", 32'(rsp_valid), ((c - 1) % 2 == 0) ? 32'd1 : 32'd2);
        check_value("rr_rdata", rsp_rdata, ((c - 1) % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
      end
      if (c == 4) begin
        req_valid = 2'b00;
      end else begin
        #1 check_value("rr_ready", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
        @(negedge clock);
      end
    end

    // Read accepted in the same cycle as fill_start.
    req_valid = 2'b01; req_addr = 8'h02; fill_start = 1'b1; fill_data = 32'hA5A5_A5A5;
    #1 check_value("fs_ready", 32'(req_ready), 32'd1);
    check_value("fs_busy_before", 32'(fill_busy), 32'd0);
    @(negedge clock);
    fill_start = 1'b0; req_valid = 2'b00;
    check_value("fs_rsp_valid", 32'(rsp_valid), 32'd1);
    check_value("fs_rdata", rsp_rdata, 32'h1234_5678);
    check_value("fs_busy", 32'(fill_busy), 32'd1);

    busy_cycles = 0; done_pulses = 0;
    for (int c = 0; c < 24; c++) begin
      if (fill_busy) busy_cycles++;
      if (fill_done) done_pulses++;
      if (fill_busy) begin
        req_valid = 2'b11; req_addr = 8'h00;
        #1 check_value("fill_ready", 32'(req_ready), 32'd0);
      end else begin
        req_valid = 2'b00;
      end
      @(negedge clock);
    end
    check_value("fill_busy_cycles", 32'(busy_cycles), 32'd16);
    check_value("fill_done_pulses", 32'(done_pulses), 32'd1);
    do_read(0, 4'd0,  32'hA5A5_A5A5, "fill_addr0");
    do_read(0, 4'd15, 32'hA5A5_A5A5, "fill_addr15");

    // Second fill aborted by reset when the counter reaches 7.
    fill_start = 1'b1; fill_data = 32'h3C3C_3C3C;
    @(negedge clock);
    fill_start = 1'b0;
    for (int c = 0; c < 20 && !(fill_busy && ram_addr == 4'd7); c++) @(negedge clock);
    check_value("abort_at7_busy", 32'(fill_busy), 32'd1);
    check_value("abort_at7_addr", 32'(ram_addr), 32'd7);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1 check_value("abort_busy", 32'(fill_busy), 32'd0);
    check_value("abort_done", 32'(fill_done), 32'd0);
    done_pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (fill_done) done_pulses++;
    end
    check_value("abort_no_done", 32'(done_pulses), 32'd0);
    do_read(0, 4'd0,  32'h3C3C_3C3C, "abort_addr0");
    do_read(1, 4'd6,  32'h3C3C_3C3C, "abort_addr6");
    do_read(0, 4'd8,  32'hA5A5_A5A5, "abort_addr8");
    do_read(1, 4'd15, 32'hA5A5_A5A5, "abort_addr15");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
